// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core load/store path and the host loader.
// Grants are combinational; burst ownership and host starvation are registered.
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned LEN_W      = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             core_req_i,
  input  logic             core_we_i,
  input  logic [7:0]       core_addr_i,
  input  logic [7:0]       core_wdata_i,
  input  logic             core_done_i,
  output logic             core_stall_o,
  output logic [7:0]       core_rdata_o,
  input  logic             host_req_i,
  input  logic             host_we_i,
  input  logic [7:0]       host_addr_i,
  input  logic [LEN_W-1:0] host_len_i,
  input  logic [7:0]       host_wdata_i,
  output logic             host_ack_o,
  output logic [7:0]       host_rdata_o,
  output logic             host_busy_o,
  output logic [7:0]       mem_addr_o,
  output logic [7:0]       mem_wdata_o,
  output logic             mem_we_o,
  input  logic [7:0]       mem_rdata_i
);

  localparam int unsigned AW    = 8;
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [AW-1:0]    base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic             creq;
  logic             host_win;
  logic             core_win;
  logic [AW-1:0]    mem_addr_c;
  logic [7:0]       mem_wdata_c;
  logic             mem_we_c;

  // State register; reset forces IDLE immediately, even mid-burst.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      beat_q   <= '0;
      base_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
      len_q    <= len_d;
    end
  end

  // Winner selection, burst sequencing and port mux.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    beat_d      = beat_q;
    base_d      = base_q;
    len_d       = len_q;
    host_win    = 1'b0;
    core_win    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    mem_we_c    = 1'b0;

    creq = core_req_i & ~core_done_i;

    case (state_q)
      ST_IDLE: begin
        host_win = reset_i & host_req_i & (~creq | (starve_q == STARVE_LIM));
        core_win = creq & ~host_win;
        if (host_win) begin
          base_d = host_addr_i;
          len_d  = host_len_i;
          if (host_len_i != '0) begin
            state_d = ST_BURST;
            beat_d  = LEN_W'(1);
          end
        end
      end
      ST_BURST: begin
        // Dropping host_req mid-burst aborts with no access that cycle.
        if (host_req_i) begin
          host_win = 1'b1;
          if (beat_q == len_q) begin
            state_d = ST_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase

    if (!host_req_i || host_win) begin
      starve_d = '0;
    end else if (core_win && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + CNT_W'(1);
    end

    if (host_win) begin
      mem_addr_c  = (state_q == ST_BURST) ? (base_q + AW'(beat_q)) : host_addr_i;
      mem_wdata_c = host_wdata_i;
      mem_we_c    = host_we_i;
    end else if (core_win) begin
      mem_addr_c  = core_addr_i;
      mem_wdata_c = core_wdata_i;
      mem_we_c    = core_we_i;
    end
  end

  assign core_stall_o = creq & ~core_win;
  assign core_rdata_o = mem_rdata_i;
  assign host_ack_o   = host_win & reset_i;
  assign host_rdata_o = mem_rdata_i;
  assign host_busy_o  = (state_q == ST_BURST);
  assign mem_addr_o   = mem_addr_c;
  assign mem_wdata_o  = mem_wdata_c;
  assign mem_we_o     = mem_we_c & reset_i;

endmodule
